// File: rtl/alu_share_arb.sv
// Shares one ALU between the EX stage (requester 0) and the helper path (requester 1).
// Two-stage pipeline: operand register, then response register with overflow/illegal flags.

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  aluc,
  output logic [31:0] result_c,
  output logic        ovf_c,
  output logic        illegal_c
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Shifts take their amount from a[4:0] and shift b.
  always_comb begin
    result_c  = 32'h0;
    ovf_c     = 1'b0;
    illegal_c = 1'b0;
    case (aluc)
      5'd0: begin
        result_c = sum;
        ovf_c    = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      5'd1:  result_c = sum;
      5'd2: begin
        result_c = diff;
        ovf_c    = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      5'd3:  result_c = diff;
      5'd4:  result_c = a & b;
      5'd5:  result_c = a | b;
      5'd6:  result_c = a ^ b;
      5'd7:  result_c = ~(a | b);
      5'd8:  result_c = 32'($signed(a) < $signed(b));
      5'd9:  result_c = 32'(a < b);
      5'd10: result_c = b << a[4:0];
      5'd11: result_c = b >> a[4:0];
      5'd12: result_c = 32'($signed(b) >>> a[4:0]);
      5'd14: result_c = {b[15:0], 16'h0};
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

module alu_share_arb #(
  parameter int unsigned FIRST_PRIO = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [31:0]      a0,
  input  logic [31:0]      b0,
  input  logic [4:0]       aluc0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [31:0]      a1,
  input  logic [31:0]      b1,
  input  logic [4:0]       aluc1,
  output logic             gnt1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_ovf,
  output logic             rsp_illegal,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;
  localparam logic        RST_LAST = 1'(FIRST_PRIO == 0);

  logic              s1_valid;
  logic              s1_id;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [OP_W-1:0]   s1_aluc;
  logic              last_gnt;

  logic              s2_free;
  logic              s1_free;
  logic              accept;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;
  logic              alu_illegal;

  assign s2_free = !rsp_valid || rsp_ready;
  assign s1_free = !s1_valid || s2_free;

  // Round robin on a tie: the requester not granted last wins.
  assign gnt0 = !rst && s1_free && req0 && (!req1 || last_gnt);
  assign gnt1 = !rst && s1_free && req1 && (!req0 || !last_gnt);

  assign accept = gnt0 || gnt1;
  assign busy   = s1_valid || rsp_valid;

  alu u_alu (
    .a         (s1_a),
    .b         (s1_b),
    .aluc      (s1_aluc),
    .result_c  (alu_result),
    .ovf_c     (alu_ovf),
    .illegal_c (alu_illegal)
  );

  // Operand stage and arbitration history.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      last_gnt <= RST_LAST;
      s1_id    <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_aluc  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      last_gnt <= gnt1;
      s1_id    <= gnt1;
      s1_a     <= gnt1 ? a1 : a0;
      s1_b     <= gnt1 ? b1 : b0;
      s1_aluc  <= gnt1 ? aluc1 : aluc0;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  // Response stage; holds stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_ovf     <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (s1_valid && s2_free) begin
      rsp_valid   <= 1'b1;
      rsp_id      <= s1_id;
      rsp_result  <= alu_result;
      rsp_ovf     <= alu_ovf;
      rsp_illegal <= alu_illegal;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

  // Completion counters, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_id) done_cnt1 <= done_cnt1 + CNT_W'(1);
      else        done_cnt0 <= done_cnt0 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb; a second instance with FIRST_PRIO=1 covers the reset tie order.

module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, rsp_ready;
  logic [31:0] a0, b0, a1, b1;
  logic [4:0]  aluc0, aluc1;

  logic        gnt0, gnt1, rsp_valid, rsp_id, rsp_ovf, rsp_illegal, busy;
  logic [31:0] rsp_result;
  logic [15:0] done_cnt0, done_cnt1;

  logic        p_gnt0, p_gnt1, p_rsp_valid, p_rsp_id, p_rsp_ovf, p_rsp_illegal, p_busy;
  logic [31:0] p_rsp_result;
  logic [15:0] p_done_cnt0, p_done_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.FIRST_PRIO(0), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .aluc0(aluc0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .aluc1(aluc1), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_illegal(rsp_illegal),
    .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  alu_share_arb #(.FIRST_PRIO(1), .CNT_W(16)) u_dut_p1 (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .aluc0(aluc0), .gnt0(p_gnt0),
    .req1(req1), .a1(a1), .b1(b1), .aluc1(aluc1), .gnt1(p_gnt1),
    .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(p_rsp_id),
    .rsp_result(p_rsp_result), .rsp_ovf(p_rsp_ovf), .rsp_illegal(p_rsp_illegal),
    .busy(p_busy), .done_cnt0(p_done_cnt0), .done_cnt1(p_done_cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b1;
    a0 = '0; b0 = '0; aluc0 = '0; a1 = '0; b1 = '0; aluc1 = '0;
    step(); step();
    rst = 1'b0;
  endtask

  // Present one op on requester 0 for exactly one (ungated) edge.
  task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    req0 = 1'b1; a0 = a; b0 = b; aluc0 = op;
    step();
    req0 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt0 !== 16'd0 || done_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b c0=%0d c1=%0d want 0 0 0 0", rsp_valid, busy, done_cnt0, done_cnt1);
    end
  endtask

  task automatic test_basic();
    do_reset();
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; aluc0 = 5'd0;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL basic_gnt: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
    end
    step(); req0 = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_s1: valid=%b busy=%b want 0 1", rsp_valid, busy);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_rsp: v=%b id=%b res=%h ovf=%b want 1 0 0000000c 0", rsp_valid, rsp_id, rsp_result, rsp_ovf);
    end
    step();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_cnt0 !== 16'd1) begin
      errors++; $display("FAIL basic_drain: busy=%b v=%b c0=%0d want 0 0 1", busy, rsp_valid, done_cnt0);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g1;
    exp_g1 = 4'b1010;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    a0 = 32'd1; b0 = 32'd1; aluc0 = 5'd1; a1 = 32'd2; b1 = 32'd2; aluc1 = 5'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (gnt1 !== exp_g1[i] || gnt0 !== !exp_g1[i]) begin
        errors++; $display("FAIL rr_gnt[%0d]: gnt0=%b gnt1=%b want gnt1=%b", i, gnt0, gnt1, exp_g1[i]);
      end
      step();
      if (i >= 1) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_g1[i-1]) begin
          errors++; $display("FAIL rr_id[%0d]: v=%b id=%b want 1 %b", i, rsp_valid, rsp_id, exp_g1[i-1]);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd4) begin
      errors++; $display("FAIL rr_last: v=%b id=%b res=%h want 1 1 00000004", rsp_valid, rsp_id, rsp_result);
    end
    step();
    checks++;
    if (done_cnt0 !== 16'd2 || done_cnt1 !== 16'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL rr_cnt: c0=%0d c1=%0d busy=%b want 2 2 0", done_cnt0, done_cnt1, busy);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [4:0]  vop [3];
    logic [31:0] vr [3];
    logic        vo [3];
    va = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    vb = '{32'h1, 32'h1, 32'h1};
    vop = '{5'd0, 5'd2, 5'd1};
    vr = '{32'h80000000, 32'h7FFFFFFF, 32'h80000001};
    vo = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue0(va[i], vb[i], vop[i]);
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== vr[i] || rsp_ovf !== vo[i] || rsp_illegal !== 1'b0) begin
        errors++;
        $display("FAIL ovf[%0d]: v=%b res=%h ovf=%b ill=%b want 1 %h %b 0", i, rsp_valid, rsp_result, rsp_ovf, rsp_illegal, vr[i], vo[i]);
      end
    end
    step();
  endtask

  task automatic test_alu_ops();
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [4:0]  vop [10];
    logic [31:0] vr [10];
    va  = '{32'd5, 32'h0F0F, 32'h0F0F, 32'h0F0F, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd4, 32'd4};
    vb  = '{32'd7, 32'h00FF, 32'h00FF, 32'h00FF, 32'h0, 32'h1, 32'h1, 32'h1, 32'h80000000, 32'h80000000};
    vop = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
    vr  = '{32'hFFFFFFFE, 32'h0000000F, 32'h00000FFF, 32'h00000FF0, 32'hFFFFFFFF,
            32'h1, 32'h0, 32'h10, 32'h08000000, 32'hF8000000};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      issue0(va[i], vb[i], vop[i]);
      step();
      checks++;
      if (rsp_result !== vr[i] || rsp_ovf !== 1'b0 || rsp_illegal !== 1'b0) begin
        errors++;
        $display("FAIL alu_op%0d: res=%h ovf=%b ill=%b want %h 0 0", vop[i], rsp_result, rsp_ovf, rsp_illegal, vr[i]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    issue0(32'd1, 32'd2, 5'd0);
    req1 = 1'b1; a1 = 32'd10; b1 = 32'd20; aluc1 = 5'd0;
    #1;
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++; $display("FAIL bp_second_gnt: gnt1=%b want 1", gnt1);
    end
    step();
    req1 = 1'b0;
    req0 = 1'b1; a0 = 32'd100; b0 = 32'd1; aluc0 = 5'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (gnt0 !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd3) begin
        errors++;
        $display("FAIL bp_hold[%0d]: gnt0=%b v=%b id=%b res=%h want 0 1 0 00000003", i, gnt0, rsp_valid, rsp_id, rsp_result);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL bp_third_gnt: gnt0=%b want 1", gnt0);
    end
    step();
    req0 = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd30) begin
      errors++; $display("FAIL bp_drain1: v=%b id=%b res=%h want 1 1 0000001e", rsp_valid, rsp_id, rsp_result);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd101) begin
      errors++; $display("FAIL bp_drain2: v=%b id=%b res=%h want 1 0 00000065", rsp_valid, rsp_id, rsp_result);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done_cnt0 !== 16'd2 || done_cnt1 !== 16'd1) begin
      errors++; $display("FAIL bp_cnt: busy=%b c0=%0d c1=%0d want 0 2 1", busy, done_cnt0, done_cnt1);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    issue0(32'd1, 32'd1, 5'd13);
    step();
    checks++;
    if (rsp_illegal !== 1'b1 || rsp_result !== 32'h0 || rsp_ovf !== 1'b0) begin
      errors++; $display("FAIL illegal13: ill=%b res=%h ovf=%b want 1 0 0", rsp_illegal, rsp_result, rsp_ovf);
    end
    issue0(32'd1, 32'h00001234, 5'd14);
    step();
    checks++;
    if (rsp_illegal !== 1'b0 || rsp_result !== 32'h12340000) begin
      errors++; $display("FAIL lui14: ill=%b res=%h want 0 12340000", rsp_illegal, rsp_result);
    end
    issue0(32'd3, 32'd4, 5'd31);
    step();
    checks++;
    if (rsp_illegal !== 1'b1 || rsp_result !== 32'h0) begin
      errors++; $display("FAIL illegal31: ill=%b res=%h want 1 0", rsp_illegal, rsp_result);
    end
    step();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    rsp_ready = 1'b0;
    issue0(32'd1, 32'd1, 5'd0);
    issue0(32'd2, 32'd2, 5'd0);
    checks++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL inflight_setup: v=%b busy=%b want 1 1", rsp_valid, busy);
    end
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL rst_gnt: gnt0=%b gnt1=%b want 0 0", gnt0, gnt1);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt0 !== 16'd0 || done_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL rst_flush: v=%b busy=%b c0=%0d c1=%0d want 0 0 0 0", rsp_valid, busy, done_cnt0, done_cnt1);
    end
    rst = 1'b0;
    a0 = 32'd7; b0 = 32'd0; aluc0 = 5'd0; a1 = 32'd9; b1 = 32'd0; aluc1 = 5'd0;
    #1;
    checks++;
    if (p_gnt1 !== 1'b1 || p_gnt0 !== 1'b0 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL tie_after_rst: p1 gnt0=%b gnt1=%b p0 gnt0=%b gnt1=%b want 0 1 1 0", p_gnt0, p_gnt1, gnt0, gnt1);
    end
    step();
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || p_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL no_stale: v=%b pv=%b want 0 0", rsp_valid, p_rsp_valid);
    end
    step();
    checks++;
    if (p_rsp_id !== 1'b1 || p_rsp_result !== 32'd9 || rsp_id !== 1'b0 || rsp_result !== 32'd7) begin
      errors++;
      $display("FAIL tie_rsp: p1 id=%b res=%h p0 id=%b res=%h want 1 9 0 7", p_rsp_id, p_rsp_result, rsp_id, rsp_result);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_overflow();
    test_alu_ops();
    test_backpressure();
    test_illegal();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Arbitrates one `alu` instance between two requesters: requester 0 is the pipeline EX stage, requester 1 is the multicycle/exception helper path.
- Accepted operations pass through a two-stage pipeline:
  - Stage 1 (operand register) feeds the ALU.
  - Stage 2 (response register) holds the result.
- Adds signed-overflow and illegal-opcode flags.
- Supports response backpressure.

Parameters:
- FIRST_PRIO, 0: requester that wins the first tie after reset (0 or 1).
- CNT_W, 16: width of the per-requester completion counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 has an operation pending.
- a0  in  32  requester 0 operand a (shift amount for shifts).
- b0  in  32  requester 0 operand b.
- aluc0  in  5  requester 0 ALU op code.
- gnt0  out  1  combinational; req0 accepted this cycle.
- req1, a1, b1, aluc1  in  1/32/32/5  requester 1, same meaning.
- gnt1  out  1  combinational; req1 accepted this cycle.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  32  ALU result.
- rsp_ovf  out  1  signed overflow (add/sub only).
- rsp_illegal  out  1  aluc is not in {0..12, 14}.
- busy  out  1  stage 1 or stage 2 valid.
- done_cnt0, done_cnt1  out  CNT_W  responses consumed per requester.

Behaviour:

Reset:
- Requirements: rst synchronous and active-high.
- Clears s1_valid, rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_illegal, done_cnt0 and done_cnt1.
- Sets last_gnt = ~FIRST_PRIO.
- An in-flight operation is discarded; no response is produced for it.
- gnt0 and gnt1 are 0 while rst is high.

Advance rules:
- s2_free = !rsp_valid | rsp_ready.
- s1_free = !s1_valid | s2_free.

Arbitration (combinational):
- gnt0 and gnt1 are only ever asserted while s1_free is high.
- Only req0 high: gnt0 = 1.
- Only req1 high: gnt1 = 1.
- Both high: grant goes to ~last_gnt (round robin).
- At most one grant per cycle.
- An accept is req & gnt at the clock edge.
- A requester holds req, a, b and aluc stable until granted.
- The block never grants a requester whose req is low.

Stage 1:
- On accept, latch {id, a, b, aluc} and set s1_valid; last_gnt = id.
- When stage 1 moves to stage 2 with no new accept, s1_valid clears.
- If stage 1 cannot move (s2 stalled), it holds.

Stage 2:
- When s1_valid & s2_free, load rsp_result = alu(s1_a, s1_b, s1_aluc), rsp_id, rsp_ovf, rsp_illegal; rsp_valid = 1.
- Else, if rsp_ready, rsp_valid clears.
- While rsp_valid & !rsp_ready, all response outputs hold stable.

Flags:
- ovf for aluc 0 (add): a[31]==b[31] and r[31]!=a[31].
- ovf for aluc 2 (sub): a[31]!=b[31] and r[31]!=a[31].
- ovf is 0 for every other opcode, including 1 and 3.
- illegal = (aluc==13) | (aluc>14); rsp_result is then 0.

Latency and throughput:
- Accept at edge N gives rsp_valid at edge N+1.
- Sustained throughput is 1 op/cycle when rsp_ready is held high.
- Maximum 2 ops in flight.

Counters:
- done_cntX increments when rsp_valid & rsp_ready & rsp_id==X.
- Counters wrap modulo 2^CNT_W.

busy = s1_valid | rsp_valid.

Test Plan:
1. rst, then req0 with a=5, b=7, aluc=0, rsp_ready=1 -> gnt0=1 in the same cycle; next edge rsp_valid=1, rsp_id=0, rsp_result=12, rsp_ovf=0; busy drops after consumption.
2. req0 and req1 held high for 4 cycles with FIRST_PRIO=0 -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1 on consecutive cycles; done_cnt0=2, done_cnt1=2.
3. Overflow flag:
   - aluc=0, a=32'h7FFFFFFF, b=1 -> rsp_result=32'h80000000, rsp_ovf=1.
   - aluc=2, a=32'h80000000, b=1 -> rsp_ovf=1.
   - aluc=1 with the same operands -> rsp_ovf=0.
4. Backpressure: rsp_ready=0 with two ops accepted -> third request gets no grant; rsp outputs stable for 3 cycles. Raise rsp_ready -> results drain in order, one per cycle, and the third op is granted in the first ready cycle.
5. aluc=13, a=1, b=1 -> rsp_illegal=1, rsp_result=0. Then aluc=14, b=32'h00001234 -> rsp_result=32'h12340000, rsp_illegal=0.
6. rst asserted while s1_valid=1 and rsp_valid=1 -> next cycle rsp_valid=0, busy=0, counters 0, no stale response. After reset, a tie with FIRST_PRIO=1 grants requester 1 first.
